// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM state encoding, funct3 codes
// and the access-size decode used by both the aligner and the trap logic.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsuState_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } accSize_e;

    // Any funct3 that is not a byte or half encoding behaves as a word access.
    function automatic accSize_e accessSize(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobes/data replication and load lane
// extraction with sign or zero extension. No state, so it can be tested alone.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  stAddrLo,
    input  logic [2:0]  stFunct3,
    input  logic [31:0] stData,
    output logic [3:0]  stBe,
    output logic [31:0] stWdata,
    input  logic [1:0]  ldAddrLo,
    input  logic [2:0]  ldFunct3,
    input  logic [31:0] ldWord,
    output logic [31:0] ldData
);

    logic [7:0]  ldByte;
    logic [15:0] ldHalf;

    assign ldByte = ldWord[{ldAddrLo, 3'b000} +: 8];
    assign ldHalf = ldAddrLo[1] ? ldWord[31:16] : ldWord[15:0];

    // Store side: strobes follow the low address bits, data is replicated to every lane.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        stBe    = 4'b1111;
        stWdata = stData;
        case (accessSize(stFunct3))
            SZ_BYTE: begin
                stBe    = 4'b0001 << stAddrLo;
                stWdata = {4{stData[7:0]}};
            end
            SZ_HALF: begin
                stBe    = 4'b0011 << {stAddrLo[1], 1'b0};
                stWdata = {2{stData[15:0]}};
            end
            default: begin
                stBe    = 4'b1111;
                stWdata = stData;
            end
        endcase
    end

    // Load side: pick the addressed lane, then extend according to funct3.
    always_comb begin
        ldData = ldWord;
        case (ldFunct3)
            F3_B:    ldData = {{24{ldByte[7]}}, ldByte};
            F3_BU:   ldData = {24'b0, ldByte};
            F3_H:    ldData = {{16{ldHalf[15]}}, ldHalf};
            F3_HU:   ldData = {16'b0, ldHalf};
            default: ldData = ldWord;
        endcase
    end

endmodule

// File: rtl/lsu_mem_bridge.sv
// Load/store unit bridging the M stage to a req/ack data bus with wait states
// and a bounded wait. Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned
// half/word accesses fault without touching the bus).
module lsu_mem_bridge
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int TO_W        = 8
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    input  logic [2:0]  funct3,
    output logic [31:0] ReadData,
    output logic        lsu_stall,
    output logic        lsu_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    lsuState_e       state, nextState;
    logic [TO_W-1:0] toCnt;
    logic [31:0]     addrQ, wdataQ;
    logic [3:0]      beQ;
    logic [2:0]      funct3Q;
    logic            weQ;
    logic [3:0]      alignBe;
    logic [31:0]     alignWdata, ldData;
    logic            request, inReq, timeoutHit, misalignTrap;

    assign request    = MemReadM | MemWriteM;
    assign inReq      = (state == REQ);
    assign timeoutHit = inReq && !bus_ack && (toCnt == TO_W'(TIMEOUT_CYC - 1));

`ifdef LSU_MISALIGN_TRAP_EN
    accSize_e reqSize;
    assign reqSize      = accessSize(funct3);
    assign misalignTrap = (state == IDLE) && request &&
                          (((reqSize == SZ_HALF) && Mem_WrAddr[0]) ||
                           ((reqSize == SZ_WORD) && (Mem_WrAddr[1:0] != 2'b00)));
`else
    assign misalignTrap = 1'b0;
`endif

    lsu_align u_align (
        .stAddrLo (Mem_WrAddr[1:0]),
        .stFunct3 (funct3),
        .stData   (Mem_WrData),
        .stBe     (alignBe),
        .stWdata  (alignWdata),
        .ldAddrLo (addrQ[1:0]),
        .ldFunct3 (funct3Q),
        .ldWord   (bus_rdata),
        .ldData   (ldData)
    );

    // Bus fields are only driven while a request is outstanding; zero otherwise.
    assign bus_req   = inReq;
    assign bus_we    = inReq & weQ;
    assign bus_addr  = inReq ? {addrQ[31:2], 2'b00} : 32'h0;
    assign bus_be    = inReq ? beQ : 4'h0;
    assign bus_wdata = inReq ? wdataQ : 32'h0;

    // State register and REQ-cycle counter; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            toCnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
            state <= nextState;
            if (inReq && nextState == REQ) toCnt <= toCnt + 1'b1;
            else                           toCnt <= '0;
        end
    end

    // Next-state and stall: stall is combinational on the request in IDLE so the
    // pipeline freezes in the same cycle the access appears.
    always_comb begin
        nextState = state;
        lsu_stall = 1'b0;
        case (state)
            IDLE: begin
                lsu_stall = request && !reset;
                if (misalignTrap) nextState = DONE;
                else if (request) nextState = REQ;
            end
            REQ: begin
                lsu_stall = 1'b1;
                if (bus_ack || timeoutHit) nextState = DONE;
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Captured access fields, load result and the one-cycle fault pulse seen in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the captured fields are reset too, so the bus and ReadData come up as a clean zero.
            addrQ     <= '0;
            wdataQ    <= '0;
            beQ       <= '0;
            funct3Q   <= '0;
            weQ       <= 1'b0;
            ReadData  <= '0;
            lsu_fault <= 1'b0;
        end else begin
            lsu_fault <= timeoutHit || misalignTrap;
            if (state == IDLE && request) begin
                addrQ   <= Mem_WrAddr;
                wdataQ  <= alignWdata;
                beQ     <= alignBe;
                funct3Q <= funct3;
                weQ     <= MemWriteM;
            end
            if (inReq && bus_ack && !weQ) ReadData <= ldData;
            else if (timeoutHit)          ReadData <= '0;
        end
    end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed self-checking bench for lsu_mem_bridge. A second instance with a
// short timeout shares the stimulus and is observed only in the timeout step.
module tb_lsu_mem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM, MemReadM;
    logic [31:0] Mem_WrAddr, Mem_WrData;
    logic [2:0]  funct3;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    logic [31:0] rdA, rdB, addrA, addrB, wdA, wdB;
    logic        stA, stB, fA, fB, reqA, reqB, weA, weB;
    logic [3:0]  beA, beB;

    logic        sel;
    logic [31:0] obsRd, obsAddr, obsWd;
    logic        obsStall, obsFault, obsReq, obsWe;
    logic [3:0]  obsBe;

    int testCnt = 0;
    int failCnt = 0;

    // Results of the most recent doAccess call.
    int          stallCnt, reqCnt, faultCnt;
    logic        timedOut;
    logic [31:0] rdDone, capAddr, capWd;
    logic [3:0]  capBe;
    logic        capWe;

    always #5 clk = ~clk;

    lsu_mem_bridge u_dut (
        .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
        .Mem_WrAddr(Mem_WrAddr), .Mem_WrData(Mem_WrData), .funct3(funct3),
        .ReadData(rdA), .lsu_stall(stA), .lsu_fault(fA), .bus_req(reqA),
        .bus_we(weA), .bus_addr(addrA), .bus_be(beA), .bus_wdata(wdA),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    lsu_mem_bridge #(.TIMEOUT_CYC(4), .TO_W(3)) u_dut4 (
        .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
        .Mem_WrAddr(Mem_WrAddr), .Mem_WrData(Mem_WrData), .funct3(funct3),
        .ReadData(rdB), .lsu_stall(stB), .lsu_fault(fB), .bus_req(reqB),
        .bus_we(weB), .bus_addr(addrB), .bus_be(beB), .bus_wdata(wdB),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    assign obsRd    = sel ? rdB   : rdA;
    assign obsStall = sel ? stB   : stA;
    assign obsFault = sel ? fB    : fA;
    assign obsReq   = sel ? reqB  : reqA;
    assign obsWe    = sel ? weB   : weA;
    assign obsAddr  = sel ? addrB : addrA;
    assign obsBe    = sel ? beB   : beA;
    assign obsWd    = sel ? wdB   : wdA;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCnt++;
        assert (observed === expected) else begin
            failCnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one access from IDLE (called at posedge+1), acks on REQ cycle
    // ackAt (0 = never), drops the request once DONE is seen, and runs one
    // extra cycle so a stretched fault pulse would be counted.
    task automatic doAccess(input logic w, input logic r, input logic [31:0] a,
                            input logic [31:0] d, input logic [2:0] f,
                            input int ackAt, input logic [31:0] rdat);
        logic stallSeen, doneSeen;
        int   postCnt;
        stallCnt = 0; reqCnt = 0; faultCnt = 0;
        capAddr = '0; capWd = '0; capBe = '0; capWe = 1'b0; rdDone = '0;
        stallSeen = 1'b0; doneSeen = 1'b0; postCnt = 0;
        MemWriteM = w; MemReadM = r; Mem_WrAddr = a; Mem_WrData = d; funct3 = f;
        for (int cyc = 0; cyc < 60 && postCnt < 2; cyc++) begin
            if (obsReq) begin
                reqCnt++;
                bus_ack   = (reqCnt == ackAt);
                bus_rdata = (reqCnt == ackAt) ? rdat : 32'h0;
            end else begin
                bus_ack   = 1'b0;
                bus_rdata = 32'h0;
            end
            #3;
            if (obsStall) begin stallCnt++; stallSeen = 1'b1; end
            if (obsFault) faultCnt++;
            if (obsReq && reqCnt == 1) begin
                capAddr = obsAddr; capWd = obsWd; capBe = obsBe; capWe = obsWe;
            end
            if (stallSeen && !obsStall && !doneSeen) begin
                doneSeen  = 1'b1;
                rdDone    = obsRd;
                MemWriteM = 1'b0;
                MemReadM  = 1'b0;
            end
            if (doneSeen) postCnt++;
            tick();
        end
        timedOut  = !doneSeen;
        MemWriteM = 1'b0;
        MemReadM  = 1'b0;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
    endtask

    initial begin
        sel = 1'b0; reset = 1'b1;
        MemWriteM = 1'b0; MemReadM = 1'b0; Mem_WrAddr = '0; Mem_WrData = '0;
        funct3 = 3'b000; bus_ack = 1'b0; bus_rdata = '0;
        tick();
        tick();

        // Reset state
        check("rst ReadData", rdA, 32'h0);
        check("rst stall", {31'b0, stA}, 32'h0);
        check("rst fault", {31'b0, fA}, 32'h0);
        check("rst bus_req", {31'b0, reqA}, 32'h0);
        check("rst bus_we", {31'b0, weA}, 32'h0);
        check("rst bus_addr", addrA, 32'h0);
        check("rst bus_be", {28'b0, beA}, 32'h0);
        check("rst bus_wdata", wdA, 32'h0);
        reset = 1'b0;
        tick();

        // sb 0x103, ack on first REQ cycle
        doAccess(1'b1, 1'b0, 32'h0000_0103, 32'h0000_00A5, 3'b000, 1, 32'h0);
        check("sb done", {31'b0, timedOut}, 32'h0);
        check("sb be", {28'b0, capBe}, 32'h8);
        check("sb wdata", capWd, 32'hA5A5_A5A5);
        check("sb addr", capAddr, 32'h0000_0100);
        check("sb we", {31'b0, capWe}, 32'h1);
        check("sb stall", stallCnt, 2);
        check("sb req", reqCnt, 1);
        check("sb fault", faultCnt, 0);
        check("sb ReadData", rdDone, 32'h0);

        // Load lane extraction and extension
        doAccess(1'b0, 1'b1, 32'h0000_0102, 32'h0, 3'b000, 1, 32'h0080_0000);
        check("lb 0x102", rdDone, 32'hFFFF_FF80);
        check("lb we", {31'b0, capWe}, 32'h0);
        doAccess(1'b0, 1'b1, 32'h0000_0102, 32'h0, 3'b100, 1, 32'h0080_0000);
        check("lbu 0x102", rdDone, 32'h0000_0080);
        doAccess(1'b0, 1'b1, 32'h0000_0102, 32'h0, 3'b101, 1, 32'h0080_0000);
        check("lhu 0x102", rdDone, 32'h0000_0080);
        doAccess(1'b0, 1'b1, 32'h0000_0102, 32'h0, 3'b001, 1, 32'h8001_0000);
        check("lh 0x102", rdDone, 32'hFFFF_8001);
        doAccess(1'b0, 1'b1, 32'h0000_0100, 32'h0, 3'b101, 1, 32'h1234_ABCD);
        check("lhu 0x100", rdDone, 32'h0000_ABCD);
        doAccess(1'b0, 1'b1, 32'h0000_0101, 32'h0, 3'b000, 1, 32'h0000_7F00);
        check("lb 0x101", rdDone, 32'h0000_007F);
        check("lb stall", stallCnt, 2);

        // Half and word stores
        doAccess(1'b1, 1'b0, 32'h0000_0102, 32'h1234_BEEF, 3'b001, 1, 32'h0);
        check("sh be", {28'b0, capBe}, 32'hC);
        check("sh wdata", capWd, 32'hBEEF_BEEF);
        check("sh addr", capAddr, 32'h0000_0100);
        check("sh keeps ReadData", rdDone, 32'h0000_007F);
        doAccess(1'b1, 1'b0, 32'h0000_0204, 32'hDEAD_BEEF, 3'b010, 1, 32'h0);
        check("sw be", {28'b0, capBe}, 32'hF);
        check("sw wdata", capWd, 32'hDEAD_BEEF);
        check("sw addr", capAddr, 32'h0000_0204);

        // bus_ack while idle is ignored
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        #3;
        check("idle ack req", {31'b0, reqA}, 32'h0);
        check("idle ack stall", {31'b0, stA}, 32'h0);
        tick();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        #3;
        check("idle ack ReadData", rdA, 32'h0000_007F);
        tick();

        // Read and write together is a store
        doAccess(1'b1, 1'b1, 32'h0000_0104, 32'h0000_0011, 3'b000, 1, 32'h5555_5555);
        check("rw we", {31'b0, capWe}, 32'h1);
        check("rw be", {28'b0, capBe}, 32'h1);
        check("rw wdata", capWd, 32'h1111_1111);
        check("rw ReadData", rdDone, 32'h0000_007F);

        // Misaligned word store
        doAccess(1'b1, 1'b0, 32'h0000_0101, 32'h0BAD_F00D, 3'b010, 1, 32'h0);
        check("misal done", {31'b0, timedOut}, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("misal req", reqCnt, 0);
        check("misal fault", faultCnt, 1);
        check("misal stall", stallCnt, 1);
        check("misal ReadData", rdDone, 32'h0000_007F);
`else
        check("misal be", {28'b0, capBe}, 32'hF);
        check("misal addr", capAddr, 32'h0000_0100);
        check("misal we", {31'b0, capWe}, 32'h1);
        check("misal wdata", capWd, 32'h0BAD_F00D);
        check("misal fault", faultCnt, 0);
        check("misal stall", stallCnt, 2);
`endif

        // lw with five wait states
        doAccess(1'b0, 1'b1, 32'h0000_0200, 32'h0, 3'b010, 5, 32'hCAFE_F00D);
        check("lw wait req", reqCnt, 5);
        check("lw wait stall", stallCnt, 6);
        check("lw wait ReadData", rdDone, 32'hCAFE_F00D);
        check("lw wait fault", faultCnt, 0);

        // Reset in the middle of an access
        MemReadM = 1'b1; Mem_WrAddr = 32'h0000_0500; funct3 = 3'b010;
        tick();
        tick();
        check("mid pre req", {31'b0, reqA}, 32'h1);
        reset = 1'b1;
        #1;
        check("mid rst req", {31'b0, reqA}, 32'h0);
        check("mid rst stall", {31'b0, stA}, 32'h0);
        check("mid rst ReadData", rdA, 32'h0);
        check("mid rst addr", addrA, 32'h0);
        check("mid rst be", {28'b0, beA}, 32'h0);
        MemReadM = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // Clean access after reset; undefined funct3 behaves as word
        doAccess(1'b0, 1'b1, 32'h0000_0300, 32'h0, 3'b011, 2, 32'h89AB_CDEF);
        check("post rst done", {31'b0, timedOut}, 32'h0);
        check("f3 011 ReadData", rdDone, 32'h89AB_CDEF);
        check("f3 011 be", {28'b0, capBe}, 32'hF);
        check("f3 011 addr", capAddr, 32'h0000_0300);
        check("f3 011 stall", stallCnt, 3);

        // Timeout on the short-timeout instance
        sel = 1'b1;
        doAccess(1'b0, 1'b1, 32'h0000_0400, 32'h0, 3'b010, 0, 32'h0);
        check("to done", {31'b0, timedOut}, 32'h0);
        check("to req", reqCnt, 4);
        check("to stall", stallCnt, 5);
        check("to fault", faultCnt, 1);
        check("to ReadData", rdDone, 32'h0);
        #3;
        check("to idle req", {31'b0, reqB}, 32'h0);
        check("to idle stall", {31'b0, stB}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
